// File: rtl/multi_mode_shift_register.sv
// Multi-mode word shift register: forward/backward shift, rotate, clear, with saturating fill level.
// Rotate in mode 10 is built only when MULTI_MODE_SHIFT_REGISTER_ROTATE_EN is defined; otherwise mode 10 holds.
module multi_mode_shift_register #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       dataIn,
  output logic [WIDTH-1:0]       dataOut,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [CW-1:0]          fillCount,
  output logic                   full
);

  typedef enum logic [1:0] {
    ModeFwd = 2'b00,
    ModeBwd = 2'b01,
    ModeRot = 2'b10,
    ModeClr = 2'b11
  } mode_e;

  localparam logic [CW-1:0] FillMax = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] stage_d, stage_q;
  logic [CW-1:0]               fill_d, fill_q;
  logic                        full_d, full_q;
  logic [CW-1:0]               fill_inc;
  mode_e                       mode_sel;

  assign mode_sel = mode_e'(mode);
  // Saturate instead of wrapping once every stage holds an inserted word.
  assign fill_inc = (fill_q == FillMax) ? fill_q : fill_q + CW'(1);

  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (enable) begin
      unique case (mode_sel)
        ModeFwd: begin
          stage_d[0] = dataIn;
          for (int unsigned k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
          end
          fill_d = fill_inc;
        end
        ModeBwd: begin
          stage_d[DEPTH-1] = dataIn;
          for (int unsigned k = 0; k < DEPTH - 1; k++) begin
            stage_d[k] = stage_q[k+1];
          end
          fill_d = fill_inc;
        end
        ModeRot: begin
`ifdef MULTI_MODE_SHIFT_REGISTER_ROTATE_EN
          stage_d[0] = stage_q[DEPTH-1];
          for (int unsigned k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
          end
`else
          stage_d = stage_q;
`endif
        end
        ModeClr: begin
          stage_d = '0;
          fill_d  = '0;
        end
        default: ;
      endcase
    end
    // Registered from the next fill value so it rises on the edge that fills the last stage.
    full_d = (fill_d == FillMax);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      fill_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
      full_q  <= full_d;
    end
  end

  assign taps      = stage_q;
  assign dataOut   = stage_q[DEPTH-1];
  assign fillCount = fill_q;
  assign full      = full_q;

endmodule

// File: tb/tb_multi_mode_shift_register.sv
// Directed and random-soak bench for multi_mode_shift_register (WIDTH=8, DEPTH=4).
// Expectations for mode 10 follow MULTI_MODE_SHIFT_REGISTER_ROTATE_EN as defined for this build.
module tb_multi_mode_shift_register;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [7:0]  dataIn;
  logic [7:0]  dataOut;
  logic [31:0] taps;
  logic [2:0]  fillCount;
  logic        full;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] m_stage [DEPTH];
  int         m_fill;

  always #5 clk = ~clk;

  multi_mode_shift_register #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .mode     (mode),
    .dataIn   (dataIn),
    .dataOut  (dataOut),
    .taps     (taps),
    .fillCount(fillCount),
    .full     (full)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle at the falling edge before sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    rst = 1'b0; enable = 1'b1; mode = 2'b00; dataIn = d;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; mode = 2'b00; dataIn = 8'hFF;
    tick();
    rst = 1'b0;
  endtask

  task automatic fill4();
    do_reset();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
  endtask

  task automatic model_step(input logic r, input logic en, input logic [1:0] md,
                            input logic [7:0] d);
    logic [7:0] t;
    if (r) begin
      for (int k = 0; k < DEPTH; k++) m_stage[k] = 8'h00;
      m_fill = 0;
    end else if (en) begin
      case (md)
        2'b00: begin
          for (int k = DEPTH - 1; k > 0; k--) m_stage[k] = m_stage[k-1];
          m_stage[0] = d;
          if (m_fill < DEPTH) m_fill++;
        end
        2'b01: begin
          for (int k = 0; k < DEPTH - 1; k++) m_stage[k] = m_stage[k+1];
          m_stage[DEPTH-1] = d;
          if (m_fill < DEPTH) m_fill++;
        end
        2'b10: begin
`ifdef MULTI_MODE_SHIFT_REGISTER_ROTATE_EN
          t = m_stage[DEPTH-1];
          for (int k = DEPTH - 1; k > 0; k--) m_stage[k] = m_stage[k-1];
          m_stage[0] = t;
`else
          t = 8'h00;
`endif
        end
        default: begin
          for (int k = 0; k < DEPTH; k++) m_stage[k] = 8'h00;
          m_fill = 0;
        end
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; mode = 2'b00; dataIn = 8'hFF;
    @(negedge clk);

    // Reset dominates enable/mode/dataIn.
    tick(); tick();
    check("rst_taps", taps, 32'h0);
    check("rst_dout", {24'h0, dataOut}, 32'h0);
    check("rst_fill", {29'h0, fillCount}, 32'd0);
    check("rst_full", {31'h0, full}, 32'd0);
    rst = 1'b0;

    // Forward fill
    push(8'h11);
    check("fwd1_fill", {29'h0, fillCount}, 32'd1);
    push(8'h22); push(8'h33);
    check("fwd3_full", {31'h0, full}, 32'd0);
    check("fwd3_dout", {24'h0, dataOut}, 32'h00);
    push(8'h44);
    check("fwd4_taps", taps, 32'h11223344);
    check("fwd4_dout", {24'h0, dataOut}, 32'h11);
    check("fwd4_fill", {29'h0, fillCount}, 32'd4);
    check("fwd4_full", {31'h0, full}, 32'd1);
    push(8'h55);
    check("fwd5_taps", taps, 32'h22334455);
    check("fwd5_dout", {24'h0, dataOut}, 32'h22);
    check("fwd5_fill", {29'h0, fillCount}, 32'd4);
    check("fwd5_full", {31'h0, full}, 32'd1);

    // Backward shift, then hold
    fill4();
    enable = 1'b1; mode = 2'b01; dataIn = 8'hAA;
    tick();
    check("bwd_taps", taps, 32'hAA112233);
    check("bwd_dout", {24'h0, dataOut}, 32'hAA);
    check("bwd_fill", {29'h0, fillCount}, 32'd4);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mode = 2'(i + 1); dataIn = 8'(8'h5C + i);
      tick();
    end
    check("hold_taps", taps, 32'hAA112233);
    check("hold_fill", {29'h0, fillCount}, 32'd4);
    check("hold_full", {31'h0, full}, 32'd1);

    // Rotate
    fill4();
    enable = 1'b1; mode = 2'b10; dataIn = 8'hEE;
    tick();
`ifdef MULTI_MODE_SHIFT_REGISTER_ROTATE_EN
    check("rot1_taps", taps, 32'h22334411);
    check("rot1_dout", {24'h0, dataOut}, 32'h22);
`else
    check("rot1_taps", taps, 32'h11223344);
    check("rot1_dout", {24'h0, dataOut}, 32'h11);
`endif
    tick(); tick(); tick();
    check("rot4_taps", taps, 32'h11223344);
    check("rot4_fill", {29'h0, fillCount}, 32'd4);

    // Clear is gated by enable
    do_reset();
    push(8'h11); push(8'h22);
    enable = 1'b0; mode = 2'b11;
    tick();
    check("clr_gated", taps, 32'h00001122);
    enable = 1'b1;
    tick();
    check("clr_taps", taps, 32'h0);
    check("clr_fill", {29'h0, fillCount}, 32'd0);
    check("clr_full", {31'h0, full}, 32'd0);
    push(8'h77);
    check("clr_push_fill", {29'h0, fillCount}, 32'd1);
    check("clr_push_taps", taps, 32'h00000077);

    // Clear from full drops full
    fill4();
    enable = 1'b1; mode = 2'b11;
    tick();
    check("clrfull_full", {31'h0, full}, 32'd0);

    // Reset mid-fill
    do_reset();
    push(8'h01); push(8'h02); push(8'h03);
    enable = 1'b1; mode = 2'b01; dataIn = 8'h99; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_taps", taps, 32'h0);
    check("rstmid_fill", {29'h0, fillCount}, 32'd0);

    // Backward insert is visible on dataOut right away
    enable = 1'b1; mode = 2'b01; dataIn = 8'h5A;
    tick();
    check("bwd_first_dout", {24'h0, dataOut}, 32'h5A);
    check("bwd_first_fill", {29'h0, fillCount}, 32'd1);

    // Random soak against the reference model
    do_reset();
    for (int k = 0; k < DEPTH; k++) m_stage[k] = 8'h00;
    m_fill = 0;
    for (int i = 0; i < 5000; i++) begin
      rst    = ($urandom_range(63) == 0);
      enable = ($urandom_range(3) != 0);
      mode   = 2'($urandom_range(3));
      dataIn = 8'($urandom);
      model_step(rst, enable, mode, dataIn);
      tick();
      check("soak_taps", taps, {m_stage[3], m_stage[2], m_stage[1], m_stage[0]});
      check("soak_dout", {24'h0, dataOut}, {24'h0, m_stage[DEPTH-1]});
      check("soak_fill", {29'h0, fillCount}, 32'(m_fill));
      check("soak_full", {31'h0, full}, {31'h0, (m_fill == DEPTH)});
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
